// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, key map
// and column-pattern decoding.
package keypad_pkg;

  typedef enum logic [2:0] {
    SCAN,
    DEBOUNCE,
    CONFIRM,
    HOLD,
    RELEASE_DB
  } state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // Physical legend of the keypad, indexed [row][col].
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'hE;
      4'hD:    code = 4'h0;
      4'hE:    code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic onehot_low(input logic [3:0] col);
    logic [3:0] act;
    act = ~col;
    return (act != 4'b0000) && ((act & (act - 4'd1)) == 4'b0000);
  endfunction

  // Column index of the low bit; only meaningful when onehot_low() holds.
  function automatic logic [1:0] low_index(input logic [3:0] col);
    logic [1:0] idx;
    if (!col[0])      idx = 2'd0;
    else if (!col[1]) idx = 2'd1;
    else if (!col[2]) idx = 2'd2;
    else              idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_timer.sv
// Up-counter with synchronous clear and enable; done flags the terminal
// count MAX-1, after which the count wraps to zero.
module keypad_timer #(
  parameter int MAX = 4,
  parameter int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic done
);

  logic [W-1:0] count;

  assign done = (count == W'(MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= done ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad controller: one-hot active-low row scan, synchronized columns,
// press/release debounce, hex encoding and a two-digit display history.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV        = 4096,
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       busy
);

  import keypad_pkg::*;

  state_t     state;
  state_t     next_state;
  logic [3:0] col_meta;
  logic [3:0] col_s;
  logic [1:0] row_idx;
  logic [3:0] latched_col;
  logic       dwell_done;
  logic       db_done;
  logic       dwell_clear;
  logic       db_clear;
  logic       advance_row;
  logic       latch_key;
  logic       accept;
  logic [3:0] accepted_code;

  keypad_timer #(.MAX(SCAN_DIV)) u_dwell (
    .clk   (int_osc),
    .rst   (reset),
    .clear (dwell_clear),
    .en    (1'b1),
    .done  (dwell_done)
  );

  keypad_timer #(.MAX(DEBOUNCE_CYCLES)) u_debounce (
    .clk   (int_osc),
    .rst   (reset),
    .clear (db_clear),
    .en    (1'b1),
    .done  (db_done)
  );

  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      state <= SCAN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    advance_row = 1'b0;
    latch_key   = 1'b0;
    accept      = 1'b0;
    case (state)
      SCAN: begin
        if (dwell_done) begin
          if (onehot_low(col_s)) begin
            next_state = DEBOUNCE;
            latch_key  = 1'b1;
          end else begin
            advance_row = 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        if (col_s != latched_col) begin
          next_state  = SCAN;
          advance_row = 1'b1;
        end else if (db_done) begin
          next_state = CONFIRM;
        end
      end
      CONFIRM: begin
        if (col_s == latched_col) begin
          next_state = HOLD;
          accept     = 1'b1;
        end else begin
          next_state  = SCAN;
          advance_row = 1'b1;
        end
      end
      HOLD: begin
        if (col_s == 4'b1111) begin
          next_state = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (col_s != 4'b1111) begin
          next_state = HOLD;
        end else if (db_done) begin
          next_state  = SCAN;
          advance_row = 1'b1;
        end
      end
      default: begin
        next_state = SCAN;
      end
    endcase
  end

  // Timers sit cleared outside their owning states, so every entry starts at 0.
  always_comb begin
    row_n       = ~(4'b0001 << row_idx);
    busy        = (state != SCAN);
    dwell_clear = (state != SCAN) || dwell_done;
    db_clear    = !((state == DEBOUNCE) || (state == RELEASE_DB));
  end

  // The row index is frozen outside SCAN, so it doubles as the latched key row.
  assign accepted_code = key_map(row_idx, low_index(latched_col));

  // key_valid: single-cycle strobe, no backpressure; key_code and the digit
  // history are updated on the same edge and stay stable until the next strobe.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      col_meta    <= 4'b1111;
      col_s       <= 4'b1111;
      row_idx     <= 2'd0;
      latched_col <= 4'b1111;
      key_valid   <= 1'b0;
      key_code    <= 4'h0;
      digit_new   <= 4'h0;
      digit_old   <= 4'h0;
    end else begin
      col_meta  <= col_n;
      col_s     <= col_meta;
      key_valid <= accept;
      if (advance_row) begin
        row_idx <= row_idx + 2'd1;
      end
      if (latch_key) begin
        latched_col <= col_s;
      end
      if (accept) begin
        key_code  <= accepted_code;
        digit_old <= digit_new;
        digit_new <= accepted_code;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a physical keypad model drives the columns,
// accepted presses queue expected codes/digits, and a monitor checks each pulse.
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 8;

  logic        int_osc = 1'b0;
  logic        reset   = 1'b1;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [3:0]  digit_new;
  logic [3:0]  digit_old;
  logic        busy;

  logic [15:0] pressed = '0;
  int          checks  = 0;
  int          errors  = 0;
  logic [11:0] exp_q[$];
  logic [3:0]  exp_new = 4'h0;
  logic [3:0]  exp_old = 4'h0;
  logic [11:0] mon_e;
  logic [3:0]  key_tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DB)) dut (
    .int_osc   (int_osc),
    .reset     (reset),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .digit_new (digit_new),
    .digit_old (digit_old),
    .busy      (busy)
  );

  // Clock / reset
  always #5 int_osc = ~int_osc;

  // Keypad: a pressed key shorts its column low while its row is driven low.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge int_osc);
    #1;
  endtask

  task automatic expect_key(input int r, input int c);
    logic [3:0] code;
    code    = key_tbl[r*4+c];
    exp_old = exp_new;
    exp_new = code;
    exp_q.push_back({code, exp_new, exp_old});
  endtask

  task automatic tap(input int r, input int c, input int hold, input int gap, input bit accepted);
    if (accepted) expect_key(r, c);
    pressed[r*4+c] = 1'b1;
    cycles(hold);
    pressed = '0;
    cycles(gap);
    check("episode_drain", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic wait_busy(input logic level, input string name);
    int n;
    n = 0;
    while (busy !== level && n < 60) begin
      cycles(1);
      n++;
    end
    check(name, {15'd0, busy}, {15'd0, level});
  endtask

  // Scoreboard monitor
  always @(negedge int_osc) begin
    if (!reset && key_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse key_code=%h digit_new=%h digit_old=%h",
                 key_code, digit_new, digit_old);
      end else begin
        mon_e = exp_q.pop_front();
        check("key_code", {12'd0, key_code}, {12'd0, mon_e[11:8]});
        check("digit_new", {12'd0, digit_new}, {12'd0, mon_e[7:4]});
        check("digit_old", {12'd0, digit_old}, {12'd0, mon_e[3:0]});
      end
    end
  end

  initial begin
    int n;
    int r;
    int c;
    int c2;
    int kind;

    cycles(3);
    check("rst_row_n", {12'd0, row_n}, 16'h000E);
    check("rst_key_valid", {15'd0, key_valid}, 16'd0);
    check("rst_key_code", {12'd0, key_code}, 16'd0);
    check("rst_digits", {8'd0, digit_new, digit_old}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);

    @(negedge int_osc);
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cycles(1);
      check("idle_row_n", {12'd0, row_n}, {12'd0, ~(4'b0001 << ((k / SCAN_DIV) % 4))});
      check("idle_quiet", {14'd0, key_valid, busy}, 16'd0);
    end

    // Key '5': detect-to-pulse latency, one pulse, resume on the next row.
    expect_key(1, 1);
    pressed[5] = 1'b1;
    wait_busy(1'b1, "detect_5");
    n = 0;
    while (!key_valid && n < 40) begin
      cycles(1);
      n++;
    end
    check("accept_latency", 16'(n), 16'(DB + 1));
    cycles(80);
    pressed = '0;
    wait_busy(1'b0, "release_5");
    check("resume_row_n", {12'd0, row_n}, 16'h000B);
    check("code_5", {12'd0, key_code}, 16'h0005);
    check("digits_5_0", {8'd0, digit_new, digit_old}, 16'h0050);
    check("drain_5", 16'(exp_q.size()), 16'd0);

    // Short press of '3' released during debounce.
    tap(0, 2, 3, 30, 1'b0);
    check("short_busy", {15'd0, busy}, 16'd0);

    // '3' then 'A'.
    tap(0, 2, 60, 40, 1'b1);
    tap(0, 3, 60, 40, 1'b1);
    check("digits_A_3", {8'd0, digit_new, digit_old}, 16'h00A3);
    check("code_A", {12'd0, key_code}, 16'h000A);

    // Contact bounce during release debounce of '3': still one pulse.
    expect_key(0, 2);
    pressed[2] = 1'b1;
    cycles(60);
    pressed = '0;
    cycles(4);
    pressed[2] = 1'b1;
    cycles(2);
    pressed = '0;
    cycles(4);
    check("bounce_busy", {15'd0, busy}, 16'd1);
    cycles(40);
    check("bounce_drain", 16'(exp_q.size()), 16'd0);

    // Two-key chord on row 0 is ignored.
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    cycles(60);
    pressed = '0;
    cycles(30);
    check("chord_drain", 16'(exp_q.size()), 16'd0);

    // Randomized episodes.
    for (int e = 0; e < 16; e++) begin
      kind = $urandom_range(0, 2);
      r    = $urandom_range(0, 3);
      c    = $urandom_range(0, 3);
      if (kind == 0) begin
        tap(r, c, $urandom_range(50, 90), $urandom_range(40, 60), 1'b1);
      end else if (kind == 1) begin
        tap(r, c, $urandom_range(1, 3), $urandom_range(20, 40), 1'b0);
      end else begin
        c2 = (c + $urandom_range(1, 3)) % 4;
        pressed[r*4+c2] = 1'b1;
        tap(r, c, $urandom_range(50, 90), $urandom_range(30, 50), 1'b0);
      end
    end

    // Reset asserted mid-debounce.
    pressed[9] = 1'b1;
    wait_busy(1'b1, "detect_8");
    cycles(3);
    reset   = 1'b1;
    exp_new = 4'h0;
    exp_old = 4'h0;
    #1;
    check("mid_rst_row_n", {12'd0, row_n}, 16'h000E);
    check("mid_rst_quiet", {14'd0, key_valid, busy}, 16'd0);
    check("mid_rst_digits", {4'd0, key_code, digit_new, digit_old}, 16'd0);
    cycles(3);
    pressed = '0;
    @(negedge int_osc);
    reset = 1'b0;
    cycles(40);
    check("final_drain", 16'(exp_q.size()), 16'd0);
    check("final_digits", {8'd0, digit_new, digit_old}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
